// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} kp_state_t;

  typedef logic [3:0] key_code_t;

  // Auto-repeat timing, counted in full scans.
  localparam int REPEAT_FIRST = 32;
  localparam int REPEAT_NEXT  = 8;

endpackage

// File: rtl/counter.sv
// Free-running up-counter with enable; used as the keypad scan timebase.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // NOTE: clocked state always uses non-blocking assignments, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (enable) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with scan-level debounce.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE   = 10,
  parameter int DEBOUNCE = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic      key_valid,
  output logic      key_down
);

  localparam int CW = SETTLE + 2;
  localparam int SW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] scan_cnt;
  logic [1:0]    col_idx;
  logic          dwell_end;
  logic          scan_end;

  counter #(.WIDTH(CW)) u_timebase (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .count  (scan_cnt)
  );

  assign col_idx   = scan_cnt[CW-1 -: 2];
  assign dwell_end = &scan_cnt[SETTLE-1:0];
  assign scan_end  = dwell_end && (col_idx == 2'd3);
  assign col       = ~(4'b0001 << col_idx);

  logic [3:0] row_meta, row_sync;
  logic [3:0] col_sample [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // NOTE: this array is only sixteen flops, so it resets like ordinary
  // registers; large RAM-style arrays would be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 4; c++) col_sample[c] <= 4'hF;
    end else if (dwell_end) begin
      col_sample[col_idx] <= row_sync;
    end
  end

  // Column 3 is still being sampled at scan end, so use the live sync value.
  logic [4:0] n_pressed;
  key_code_t  hit_code;
  logic [3:0] cur_rows;
  logic       single;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    n_pressed = '0;
    hit_code  = '0;
    cur_rows  = 4'hF;
    for (int c = 0; c < 4; c++) begin
      cur_rows = (c == 3) ? row_sync : col_sample[c[1:0]];
      for (int r = 0; r < 4; r++) begin
        if (!cur_rows[r[1:0]]) begin
          n_pressed = n_pressed + 5'd1;
          hit_code  = {r[1:0], c[1:0]};
        end
      end
    end
  end

  assign single = (n_pressed == 5'd1);

  kp_state_t state;
  key_code_t cand;
  logic [SW-1:0] stable;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FIRST + 1);
  logic [RW-1:0] rep_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= '0;
      stable    <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        case (state)
          IDLE: if (single) begin
            cand   <= hit_code;
            stable <= SW'(1);
            if (DEBOUNCE == 1) begin
              state     <= HELD;
              key       <= hit_code;
              key_down  <= 1'b1;
              key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt   <= RW'(REPEAT_FIRST);
`endif
            end else begin
              state <= PRESS_DB;
            end
          end
          PRESS_DB: begin
            if (!single) begin
              state <= IDLE;
            end else if (hit_code == cand) begin
              if (int'(stable) + 1 >= DEBOUNCE) begin
                state     <= HELD;
                key       <= cand;
                key_down  <= 1'b1;
                key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= RW'(REPEAT_FIRST);
`endif
              end else begin
                stable <= stable + SW'(1);
              end
            end else begin
              cand   <= hit_code;
              stable <= SW'(1);
            end
          end
          HELD: begin
            if (!(single && hit_code == key)) begin
              if (DEBOUNCE == 1 && !single) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end else begin
                state  <= REL_DB;
                stable <= SW'(1);
              end
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
            end else if (rep_cnt == RW'(1)) begin
              key_valid <= 1'b1;
              rep_cnt   <= RW'(REPEAT_NEXT);
            end else begin
              rep_cnt <= rep_cnt - RW'(1);
`endif
            end
          end
          REL_DB: begin
            if (!single) begin
              if (int'(stable) + 1 >= DEBOUNCE) begin
                state    <= IDLE;
                key_down <= 1'b0;
                stable   <= '0;
              end else begin
                stable <= stable + SW'(1);
              end
            end else if (hit_code == key) begin
              state <= HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= RW'(REPEAT_FIRST);
`endif
            end else begin
              stable <= SW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised scoreboard bench for keypad_scanner (SETTLE=2, DEBOUNCE=3).
module tb_keypad_scanner;

  localparam int SETTLE   = 2;
  localparam int DEBOUNCE = 3;
  localparam int SCAN     = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_down;
  logic [15:0] pressed = '0;

  keypad_scanner #(.SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, one call per full scan of a steady key mask.
  logic [3:0] exp_q[$];
  bit         m_down = 0;
  logic [3:0] m_key = '0;
  int         run_code = -1;
  int         run_len = 0;
  int         gap = 0;
  int         held_scans = 0;

  task automatic model_reset();
    m_down = 0; m_key = '0; run_code = -1; run_len = 0; gap = 0; held_scans = 0;
    exp_q.delete();
  endtask

  task automatic model_scan(input logic [15:0] mask);
    int res;
    int ones;
    ones = 0;
    res  = -1;
    for (int i = 0; i < 16; i++) if (mask[i]) begin ones++; res = i; end
    if (ones != 1) res = -1;
    if (res == run_code) run_len++;
    else begin run_code = res; run_len = 1; end
    if (!m_down) begin
      if (res >= 0 && run_len == DEBOUNCE) begin
        m_down = 1; m_key = res[3:0]; gap = 0; held_scans = 0;
        exp_q.push_back(m_key);
      end
    end else if (res == int'(m_key)) begin
      if (gap > 0) begin
        gap = 0; held_scans = 0;
      end else begin
        held_scans++;
`ifdef KEYPAD_REPEAT_EN
        if (held_scans >= 32 && (held_scans - 32) % 8 == 0) exp_q.push_back(m_key);
`endif
      end
    end else begin
      if (gap == 0 || res >= 0) gap = 1;
      else gap++;
      if (gap == DEBOUNCE) m_down = 0;
    end
  endtask

  // Entered and left at a negedge in the first cycle of a scan.
  task automatic do_scan(input logic [15:0] mask, input bit check_col);
    logic [3:0] exp_col;
    pressed = mask;
    model_scan(mask);
    for (int i = 0; i < SCAN; i++) begin
      if (check_col) begin
        exp_col = ~(4'b0001 << (i / 4));
        check("col_walk", col, exp_col);
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("key_down", key_down, m_down);
    check("key", key, m_key);
  endtask

  task automatic scans(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) do_scan(mask, 1'b0);
  endtask

  // Monitor: pops an expected key for every key_valid pulse.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [3:0] exp_key;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (key_valid) begin
        check("valid_gap", prev_valid, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: key=%0h with no press expected at %0t", key, $time);
        end else begin
          exp_key = exp_q.pop_front();
          check("pulse_key", key, exp_key);
          check("pulse_down", key_down, 1);
        end
      end
      prev_valid = key_valid;
    end
  end

  initial begin
    logic [15:0] mask;
    int a, b, sel;
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 0);
    check("rst_valid", key_valid, 0);
    check("rst_down", key_down, 0);
    reset = 1'b0;
    do_scan('0, 1'b1);

    scans(16'h0040, 5);                 // row1/col2 -> key 6
    scans(16'h0000, 4);
    scans(16'h0020, 1);                 // bounce on key 5
    scans(16'h0000, 1);
    scans(16'h0020, 1);
    scans(16'h0000, 1);
    scans(16'h0020, 3);
    scans(16'h0000, 3);
    scans(16'h8001, 3);                 // ghost: keys 0 and 15
    scans(16'h0001, 3);
    scans(16'h0000, 3);
    scans(16'h0008, 3);                 // key 3 with a one-scan glitch
    scans(16'h0000, 1);
    scans(16'h0008, 2);
    scans(16'h0000, 3);
    scans(16'h0200, 60);                // key 9 long hold
    scans(16'h0000, 3);

    // Asynchronous reset in the middle of a scan while key 10 is held.
    scans(16'h0400, 4);
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_col", col, 4'b1110);
    check("mid_rst_key", key, 0);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_down", key_down, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_scan(16'h0400, 1'b1);
    scans(16'h0400, 2);
    scans(16'h0000, 3);

    mask = '0;
    for (int s = 0; s < 60; s++) begin
      sel = $urandom_range(0, 9);
      if (sel >= 5 && sel <= 6) mask = '0;
      else if (sel >= 7 && sel <= 8) mask = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 9) begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        mask = (16'h0001 << a) | (16'h0001 << b);
      end
      do_scan(mask, 1'b0);
    end
    scans(16'h0000, 4);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
